fetch_packet_gen: RTL and testbench

FETCH_PACKET_GEN -- requirements
Module: fetch_packet_gen

---
 rtl/fetch_packet_gen.sv | 241 ++++++++++++++++++++++++
 tb/tb_fetch_packet_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_packet_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_packet_gen (+ ariane_pkg types)
// Brief    : One-word-at-a-time I$ fetch unit producing two-slot packets,
//            stitching 32-bit instructions that straddle a word boundary.
// Revision : 1.0
// ============================================================================

package ariane_pkg;
  typedef enum logic [1:0] {
    FE_NONE               = 2'd0,
    FE_INSTR_ACCESS_FAULT = 2'd1,
    FE_INSTR_PAGE_FAULT   = 2'd2
  } frontend_exception_t;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;
endpackage

module fetch_packet_gen #(
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter logic [63:0] BOOT_ADDR       = 64'h8000_0000
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_redirect_i,
  input  logic [63:0]                             redirect_addr_i,
  output logic                                    icache_req_o,
  output logic [63:0]                             icache_addr_o,
  input  logic                                    icache_gnt_i,
  input  logic                                    icache_rvalid_i,
  input  logic [31:0]                             icache_rdata_i,
  input  ariane_pkg::frontend_exception_t         icache_ex_i,
  output logic [INSTR_PER_FETCH-1:0][31:0]        instr_o,
  output logic [INSTR_PER_FETCH-1:0][63:0]        addr_o,
  output logic [INSTR_PER_FETCH-1:0]              valid_o,
  output ariane_pkg::cf_t [INSTR_PER_FETCH-1:0]   cf_type_o,
  output logic [63:0]                             predict_address_o,
  output ariane_pkg::frontend_exception_t         exception_o,
  input  logic                                    ready_i,
  input  logic                                    replay_i,
  input  logic [63:0]                             replay_addr_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t      r_state, w_state_d;
  logic [63:0] r_pc, w_pc_d;
  logic [63:0] r_req_addr, w_req_addr_d;
  logic        r_redir_pend, w_redir_pend_d;
  logic        r_carry_valid, w_carry_valid_d;
  logic [15:0] r_carry_data, w_carry_data_d;
  logic [63:0] r_carry_pc, w_carry_pc_d;

  logic [63:0] w_aligned;
  logic [63:0] w_aligned_p2;
  logic [63:0] w_next_word;
  logic [15:0] w_lo;
  logic [15:0] w_hi;
  logic        w_lo_c;
  logic        w_hi_c;

  logic [INSTR_PER_FETCH-1:0]        w_slot_valid;
  logic [INSTR_PER_FETCH-1:0][31:0]  w_slot_instr;
  logic [INSTR_PER_FETCH-1:0][63:0]  w_slot_addr;
  logic                              w_cap;

  assign w_aligned    = {r_pc[63:2], 2'b00};
  assign w_aligned_p2 = w_aligned + 64'd2;
  assign w_next_word  = w_aligned + 64'd4;
  assign w_lo         = icache_rdata_i[15:0];
  assign w_hi         = icache_rdata_i[31:16];
  assign w_lo_c       = (w_lo[1:0] != 2'b11);
  assign w_hi_c       = (w_hi[1:0] != 2'b11);

  assign icache_addr_o     = r_req_addr;
  assign predict_address_o = 64'd0;

  for (genvar g = 0; g < INSTR_PER_FETCH; g++) begin : g_cf
    assign cf_type_o[g] = ariane_pkg::NoCF;
  end

  // Packet decode of the returning word; w_cap means the upper half starts
  // a 32-bit instruction that must wait for the next word.
  always_comb begin
    w_slot_valid   = '0;
    w_slot_instr   = '0;
    w_slot_addr[0] = r_pc;
    w_slot_addr[1] = w_aligned_p2;
    w_cap          = 1'b0;

    if (r_carry_valid) begin
      w_slot_valid[0] = 1'b1;
      w_slot_instr[0] = {w_lo, r_carry_data};
      w_slot_addr[0]  = r_carry_pc;
      if (w_hi_c) begin
        w_slot_valid[1] = 1'b1;
        w_slot_instr[1] = {16'h0000, w_hi};
      end else begin
        w_cap = 1'b1;
      end
    end else if (!r_pc[1]) begin
      w_slot_valid[0] = 1'b1;
      if (w_lo_c) begin
        w_slot_instr[0] = {16'h0000, w_lo};
        if (w_hi_c) begin
          w_slot_valid[1] = 1'b1;
          w_slot_instr[1] = {16'h0000, w_hi};
        end else begin
          w_cap = 1'b1;
        end
      end else begin
        w_slot_instr[0] = icache_rdata_i;
      end
    end else begin
      if (w_hi_c) begin
        w_slot_valid[0] = 1'b1;
        w_slot_instr[0] = {16'h0000, w_hi};
      end else begin
        w_cap = 1'b1;
      end
    end

    if (icache_ex_i != ariane_pkg::FE_NONE) begin
      w_slot_valid    = '0;
      w_slot_valid[0] = 1'b1;
      w_slot_instr    = '0;
      w_slot_addr[0]  = r_carry_valid ? r_carry_pc : r_pc;
      w_cap           = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_pc          <= BOOT_ADDR;
      r_req_addr    <= {BOOT_ADDR[63:2], 2'b00};
      r_redir_pend  <= 1'b0;
      r_carry_valid <= 1'b0;
      r_carry_data  <= 16'h0000;
      r_carry_pc    <= 64'd0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_req_addr    <= w_req_addr_d;
      r_redir_pend  <= w_redir_pend_d;
      r_carry_valid <= w_carry_valid_d;
      r_carry_data  <= w_carry_data_d;
      r_carry_pc    <= w_carry_pc_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_req_addr_d    = r_req_addr;
    w_redir_pend_d  = r_redir_pend;
    w_carry_valid_d = r_carry_valid;
    w_carry_data_d  = r_carry_data;
    w_carry_pc_d    = r_carry_pc;
    icache_req_o    = 1'b0;
    valid_o         = '0;
    instr_o         = w_slot_instr;
    addr_o          = w_slot_addr;
    exception_o     = ariane_pkg::FE_NONE;

    // A redirect wins over everything else in every state.
    if (flush_redirect_i) begin
      w_pc_d          = redirect_addr_i;
      w_carry_valid_d = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (!flush_redirect_i && ready_i) begin
          w_state_d    = REQ;
          w_req_addr_d = w_aligned;
        end
      end
      REQ: begin
        icache_req_o = 1'b1;
        if (flush_redirect_i) begin
          w_redir_pend_d = 1'b1;
        end
        if (icache_gnt_i) begin
          w_state_d      = (flush_redirect_i || r_redir_pend) ? DROP : WAIT;
          w_redir_pend_d = 1'b0;
        end
      end
      WAIT: begin
        if (icache_rvalid_i) begin
          w_state_d = IDLE;
          if (!flush_redirect_i) begin
            valid_o     = w_slot_valid;
            exception_o = icache_ex_i;
            w_carry_valid_d = w_cap && !replay_i;
            w_carry_data_d  = w_hi;
            w_carry_pc_d    = w_aligned_p2;
            if (icache_ex_i != ariane_pkg::FE_NONE) begin
              w_state_d = HALT;
            end
            if (replay_i) begin
              w_pc_d = replay_addr_i;
            end else if (icache_ex_i == ariane_pkg::FE_NONE) begin
              w_pc_d = w_next_word;
            end
          end
        end else if (flush_redirect_i) begin
          w_state_d = DROP;
        end
      end
      DROP: begin
        if (icache_rvalid_i) begin
          w_state_d = IDLE;
        end
      end
      HALT: begin
        if (flush_redirect_i) begin
          w_state_d = IDLE;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_packet_gen.sv
`default_nettype none
// Randomized scoreboard bench for fetch_packet_gen; the reference model
// treats fetched halfwords as a stream and carves instructions from it.
module tb_fetch_packet_gen;
  import ariane_pkg::*;

  localparam logic [63:0] BOOT = 64'h8000_0000;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 flush_redirect_i;
  logic [63:0]          redirect_addr_i;
  logic                 icache_req_o;
  logic [63:0]          icache_addr_o;
  logic                 icache_gnt_i;
  logic                 icache_rvalid_i;
  logic [31:0]          icache_rdata_i;
  frontend_exception_t  icache_ex_i;
  logic [1:0][31:0]     instr_o;
  logic [1:0][63:0]     addr_o;
  logic [1:0]           valid_o;
  cf_t  [1:0]           cf_type_o;
  logic [63:0]          predict_address_o;
  frontend_exception_t  exception_o;
  logic                 ready_i;
  logic                 replay_i;
  logic [63:0]          replay_addr_i;

  fetch_packet_gen #(.INSTR_PER_FETCH(2), .BOOT_ADDR(BOOT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .flush_redirect_i(flush_redirect_i), .redirect_addr_i(redirect_addr_i),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_gnt_i(icache_gnt_i), .icache_rvalid_i(icache_rvalid_i),
    .icache_rdata_i(icache_rdata_i), .icache_ex_i(icache_ex_i),
    .instr_o(instr_o), .addr_o(addr_o), .valid_o(valid_o),
    .cf_type_o(cf_type_o), .predict_address_o(predict_address_o),
    .exception_o(exception_o), .ready_i(ready_i),
    .replay_i(replay_i), .replay_addr_i(replay_addr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]          valid;
    logic [1:0][31:0]    instr;
    logic [1:0][63:0]    addr;
    frontend_exception_t ex;
  } pkt_t;

  typedef struct {
    logic [15:0] h;
    logic [63:0] a;
  } half_t;

  pkt_t        exp_q[$];
  half_t       hq[$];
  logic [63:0] mpc;
  bit          halted;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic redirect_model(input logic [63:0] a);
    mpc    = a;
    hq.delete();
    halted = 0;
  endtask

  // Reference: append the word's halfwords (from pc onward) to the pending
  // stream, then peel off up to two complete instructions.
  task automatic model_packet(input logic [31:0] data, input frontend_exception_t ex,
                              input bit rep, input logic [63:0] raddr);
    pkt_t        p;
    logic [63:0] al;
    int          n;
    al      = {mpc[63:2], 2'b00};
    p.valid = 2'b00;
    p.instr = '0;
    p.addr  = '0;
    p.ex    = ex;
    if (ex != FE_NONE) begin
      p.valid   = 2'b01;
      p.addr[0] = (hq.size() > 0) ? hq[0].a : mpc;
      hq.delete();
      halted = 1;
      if (rep) mpc = raddr;
      exp_q.push_back(p);
      return;
    end
    if (!mpc[1]) hq.push_back('{data[15:0], al});
    hq.push_back('{data[31:16], al + 64'd2});
    n = 0;
    while (hq.size() > 0 && n < 2) begin
      if (hq[0].h[1:0] != 2'b11) begin
        p.instr[n] = {16'h0000, hq[0].h};
        p.addr[n]  = hq[0].a;
        void'(hq.pop_front());
      end else if (hq.size() >= 2) begin
        p.instr[n] = {hq[1].h, hq[0].h};
        p.addr[n]  = hq[0].a;
        void'(hq.pop_front());
        void'(hq.pop_front());
      end else begin
        break;
      end
      p.valid[n] = 1'b1;
      n++;
    end
    if (rep) begin
      hq.delete();
      mpc = raddr;
    end else begin
      mpc = al + 64'd4;
    end
    if (p.valid != 2'b00) exp_q.push_back(p);
  endtask

  // Monitor: pops one expectation whenever the DUT presents a packet.
  always @(negedge clk_i) begin
    pkt_t p;
    if (!rst_i && (valid_o != 2'b00 || exception_o != FE_NONE)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_packet: got valid=%b ex=%0d addr0=%h expected no packet",
                 valid_o, exception_o, addr_o[0]);
      end else begin
        p = exp_q.pop_front();
        chk("valid", 64'(valid_o), 64'(p.valid));
        chk("exception", 64'(exception_o), 64'(p.ex));
        chk("cf_type", 64'({cf_type_o[1], cf_type_o[0]}), 64'({NoCF, NoCF}));
        chk("predict_addr", predict_address_o, 64'd0);
        for (int s = 0; s < 2; s++) begin
          if (p.valid[s]) begin
            chk($sformatf("instr%0d", s), 64'(instr_o[s]), 64'(p.instr[s]));
            chk($sformatf("addr%0d", s), addr_o[s], p.addr[s]);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
    icache_gnt_i     = 1'b0;
    icache_rvalid_i  = 1'b0;
    flush_redirect_i = 1'b0;
    replay_i         = 1'b0;
    icache_ex_i      = FE_NONE;
  endtask

  task automatic do_flush(input logic [63:0] a);
    flush_redirect_i = 1'b1;
    redirect_addr_i  = a;
    redirect_model(a);
    cyc();
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!icache_req_o && n < 40) begin
      cyc();
      ready_i = ($urandom_range(0, 3) != 0);
      n++;
    end
    ready_i = 1'b1;
    ok = icache_req_o;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no icache_req_o expected a request within 40 cycles");
    end
  endtask

  // fmode: 0 none, 1 redirect while requesting, 2 redirect in WAIT before
  // the response, 3 redirect in the response cycle.
  task automatic fetch_txn(input logic [31:0] data, input int gdly, input int rdly,
                           input bit rep, input logic [63:0] raddr,
                           input frontend_exception_t ex, input int fmode,
                           input logic [63:0] faddr);
    logic [63:0] a;
    bit          drop = 0;
    bit          ok;
    wait_req(ok);
    if (!ok) return;
    a = icache_addr_o;
    chk("req_addr", a, {mpc[63:2], 2'b00});
    if (fmode == 1) begin
      flush_redirect_i = 1'b1;
      redirect_addr_i  = faddr;
      redirect_model(faddr);
      drop = 1;
    end
    for (int i = 0; i < gdly; i++) begin
      cyc();
      chk("req_held", 64'(icache_req_o), 64'd1);
      chk("addr_held", icache_addr_o, a);
    end
    icache_gnt_i = 1'b1;
    cyc();
    for (int i = 0; i < rdly; i++) begin
      if (fmode == 2 && i == 0) begin
        flush_redirect_i = 1'b1;
        redirect_addr_i  = faddr;
        redirect_model(faddr);
        drop = 1;
      end
      cyc();
    end
    icache_rvalid_i = 1'b1;
    icache_rdata_i  = data;
    icache_ex_i     = ex;
    replay_i        = rep;
    replay_addr_i   = raddr;
    if (fmode == 3 || (fmode == 2 && rdly == 0)) begin
      flush_redirect_i = 1'b1;
      redirect_addr_i  = faddr;
      redirect_model(faddr);
      drop = 1;
    end
    if (!drop) model_packet(data, ex, rep, raddr);
    cyc();
  endtask

  task automatic check_halt();
    for (int i = 0; i < 4; i++) begin
      ready_i = 1'b1;
      chk("halt_no_req", 64'(icache_req_o), 64'd0);
      cyc();
    end
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else h[1:0] = 2'($urandom_range(0, 2));
    return h;
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    if ($urandom_range(0, 15) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'(2 * $urandom_range(0, 3));
    else a = {48'h0, 16'($urandom)} & ~64'h1;
    return a;
  endfunction

  initial begin
    bit ok;
    rst_i = 1'b1; ready_i = 1'b0; flush_redirect_i = 1'b0; redirect_addr_i = '0;
    icache_gnt_i = 1'b0; icache_rvalid_i = 1'b0; icache_rdata_i = '0;
    icache_ex_i = FE_NONE; replay_i = 1'b0; replay_addr_i = '0;
    redirect_model(BOOT);
    repeat (2) @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    chk("rst_req", 64'(icache_req_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_exception", 64'(exception_o), 64'(FE_NONE));
    rst_i = 1'b0;

    // Directed scenarios
    fetch_txn(32'h0041_0113, 0, 0, 0, '0, FE_NONE, 0, '0);
    fetch_txn(32'h0000_0001, 1, 1, 0, '0, FE_NONE, 0, '0);
    do_flush(64'h100);
    fetch_txn(32'h4505_4501, 0, 0, 0, '0, FE_NONE, 0, '0);
    do_flush(64'h100);
    fetch_txn(32'h0113_4501, 0, 0, 0, '0, FE_NONE, 0, '0);
    fetch_txn(32'h8082_0041, 2, 1, 0, '0, FE_NONE, 0, '0);
    do_flush(64'h100);
    fetch_txn(32'h0113_4501, 0, 0, 0, '0, FE_NONE, 0, '0);
    fetch_txn(32'h8082_0041, 0, 0, 1, 64'h10A, FE_NONE, 0, '0);
    fetch_txn(32'h4505_FFFF, 0, 0, 0, '0, FE_NONE, 0, '0);
    fetch_txn(32'h1234_5678, 0, 2, 0, '0, FE_NONE, 2, 64'h2000);
    fetch_txn(32'h0041_0113, 0, 0, 0, '0, FE_NONE, 0, '0);
    do_flush(64'h300);
    fetch_txn(32'h0041_0113, 1, 0, 0, '0, FE_INSTR_PAGE_FAULT, 0, '0);
    check_halt();
    do_flush(64'hFFFF_FFFF_FFFF_FFFE);
    fetch_txn(32'h4505_FFFF, 0, 0, 0, '0, FE_NONE, 0, '0);
    fetch_txn(32'h4505_4501, 0, 0, 0, '0, FE_NONE, 0, '0);

    // Reset while a transaction is outstanding; the late response is ignored.
    wait_req(ok);
    if (ok) begin
      icache_gnt_i = 1'b1;
      cyc();
      rst_i = 1'b1;
      #1;
      chk("midrst_req", 64'(icache_req_o), 64'd0);
      chk("midrst_valid", 64'(valid_o), 64'd0);
      cyc();
      rst_i   = 1'b0;
      ready_i = 1'b0;
      redirect_model(BOOT);
      cyc();
      icache_rvalid_i = 1'b1;
      icache_rdata_i  = 32'h4505_4501;
      cyc();
      ready_i = 1'b1;
    end
    fetch_txn(32'h0041_0113, 0, 0, 0, '0, FE_NONE, 0, '0);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      logic [31:0]         d;
      frontend_exception_t e;
      int                  fm;
      int                  r;
      d  = {rand_half(), rand_half()};
      e  = FE_NONE;
      if ($urandom_range(0, 24) == 0)
        e = ($urandom_range(0, 1) == 1) ? FE_INSTR_PAGE_FAULT : FE_INSTR_ACCESS_FAULT;
      r  = $urandom_range(0, 35);
      fm = (r < 3) ? r + 1 : 0;
      fetch_txn(d, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), rand_addr(), e, fm, rand_addr());
      if (halted) begin
        check_halt();
        do_flush(rand_addr());
      end else if ($urandom_range(0, 9) == 0) begin
        do_flush(rand_addr());
      end
    end

    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_packets: got %0d unpresented expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
